imu_sample_packetizer: RTL
==========================

Name: imu_sample_packetizer

Overview:
- Sits between the sample source / threshold event detector and the UART transmitter in the top-level pipeline.
- Captures one WIDTH-bit sample and its event flag, then frames it into a fixed 5-byte packet: sync, sample MSB, sample LSB, flags, checksum.
- Delivers the packet to the UART TX one byte at a time over a valid/ready handshake.
- Samples that arrive while a packet is in flight are dropped and counted; the drop is reported in the next packet.

Parameters:
- WIDTH, 16, sample width. Legal range 1..16. The sample is zero-extended to 16 bits before framing.
- SYNC_BYTE, 8'hA5, value of packet byte 0.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  single-cycle strobe: in_sample and in_event are valid this cycle.
- in_sample  input  WIDTH  sample value.
- in_event  input  1  threshold event flag belonging to in_sample.
- tx_data  output  8  byte offered to the UART TX.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  UART TX can accept a byte (not busy).
- busy  output  1  a packet is in flight (state != IDLE).
- pkt_done  output  1  one-cycle pulse on the cycle the checksum byte transfers.
- drop_cnt  output  8  count of dropped samples, saturating at 255.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state goes to IDLE; tx_valid=0, tx_data=0, busy=0, pkt_done=0, drop_cnt=0.
  - seq=0 and drop_pending=0.
  - Reset mid-packet abandons the packet immediately; no further bytes are emitted.
- FSM states: IDLE, SYNC, MSB, LSB, FLAGS, CSUM.
- Capture:
  - In IDLE with in_valid=1, latch the following: zero-extended sample S[15:0], in_event, drop_pending, and seq.
  - Clear drop_pending and go to SYNC.
  - Latency: in_valid at edge N gives tx_valid=1 with tx_data=SYNC_BYTE after edge N+1.
- Byte transfer:
  - A byte transfers on any edge where tx_valid && tx_ready.
  - tx_data and tx_valid are held stable while tx_ready=0.
  - tx_valid stays 1 from SYNC through CSUM; there are no bubbles between the bytes of one packet.
  - tx_data is registered.
- Byte sequence, with state advanced on each transfer:
  - SYNC_BYTE
  - S[15:8]
  - S[7:0]
  - FLAGS = {event, drop_flag, seq[5:0]}
  - CSUM = S[15:8] ^ S[7:0] ^ FLAGS
- Packet completion:
  - On CSUM transfer: pulse pkt_done, increment seq (6-bit, wraps 63 to 0), and go to IDLE with tx_valid=0.
  - Back-to-back case: if in_valid=1 on the same edge as the CSUM transfer, capture that sample and go directly to SYNC. tx_valid then stays 1 and the sample is not dropped.
- Drops:
  - in_valid=1 in any state other than IDLE, excluding the CSUM-transfer edge, counts as a drop.
  - A drop increments drop_cnt (saturating at 255; stays at 255) and sets drop_pending.
  - drop_pending is reported in the next captured packet's FLAGS bit 6.
  - drop_cnt is cleared only by reset.
- busy = (state != IDLE), registered together with state.
- tx_ready is ignored while tx_valid=0.

Test Plan:
1. Single packet, no backpressure: tx_ready=1; in_sample=16'h0007, in_event=1 -> bytes A5,00,07,80,87 on 5 consecutive edges; pkt_done pulses once with CSUM; busy=0 afterwards; seq=1.
2. Backpressure: same stimulus, with tx_ready=0 for 10 cycles after SYNC is offered -> tx_data stays A5 and tx_valid stays 1 throughout; sequence then completes unchanged; no bytes are duplicated or lost.
3. Drop and flag: after packet 1, issue in_sample=16'h000A, in_event=0; one cycle later issue in_sample=16'h0003 -> second sample dropped, drop_cnt=1; next packet for in_sample=16'h0005, in_event=0 is A5,00,05,42,47.
4. Back-to-back: assert in_valid with 16'h0009 exactly on the CSUM-transfer edge -> SYNC offered on the next cycle, tx_valid never drops, drop_cnt unchanged.
5. Reset mid-packet: assert rst_n=0 after MSB has transferred -> on the next edge tx_valid=0, busy=0, drop_cnt=0; a new sample 16'h0001 then yields A5,00,01,00,01 (seq restarted at 0).
6. Wrap and saturation:
   - Send 64 packets -> the 65th has FLAGS[5:0]=0.
   - Hold tx_ready=0 and pulse in_valid 300 times during one packet -> drop_cnt=255 and stays 255.

Source files
------------

// File: rtl/imu_sample_packetizer.sv
// imu_sample_packetizer: frames one IMU sample plus event flag into a 5-byte packet streamed over valid/ready
module imu_sample_packetizer #(
  parameter int WIDTH = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_sample,
  input  logic             in_event,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             pkt_done,
  output logic [7:0]       drop_cnt
);
  typedef enum logic [2:0] {IDLE, SYNC, MSB, LSB, FLAGS, CSUM} state_t;
  state_t state, nxt_state;
  logic [15:0] s, s_in;
  logic [7:0] flags, csum, nxt_data;
  logic [5:0] seq, pseq, seq_cap;
  logic ev, dflag, drop_pending, xfer, done, cap, drop;
  always_comb begin
    s_in = 16'(in_sample);
    xfer = tx_valid && tx_ready;
    done = state == CSUM && xfer;
    cap = in_valid && (state == IDLE || done);
    drop = in_valid && !cap;
    seq_cap = done ? seq + 6'd1 : seq;
    flags = {ev, dflag, pseq};
    csum = s[15:8] ^ s[7:0] ^ flags;
    nxt_data = state == SYNC ? s[15:8] : state == MSB ? s[7:0] : state == LSB ? flags : csum;
    nxt_state = state == SYNC ? MSB : state == MSB ? LSB : state == LSB ? FLAGS : state == FLAGS ? CSUM : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      tx_valid <= 1'b0;
      tx_data <= 8'd0;
      busy <= 1'b0;
      pkt_done <= 1'b0;
      drop_cnt <= 8'd0;
      seq <= 6'd0;
      drop_pending <= 1'b0;
      s <= 16'd0;
      ev <= 1'b0;
      dflag <= 1'b0;
      pseq <= 6'd0;
    end else begin
      pkt_done <= done;
      if (done) seq <= seq + 6'd1;
      if (drop) begin
        drop_pending <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
      if (cap) begin
        s <= s_in;
        ev <= in_event;
        dflag <= drop_pending;
        pseq <= seq_cap;
        drop_pending <= 1'b0;
        state <= SYNC;
        tx_valid <= 1'b1;
        tx_data <= SYNC_BYTE;
        busy <= 1'b1;
      end else if (done) begin
        state <= IDLE;
        tx_valid <= 1'b0;
        busy <= 1'b0;
      end else if (xfer) begin
        state <= nxt_state;
        tx_data <= nxt_data;
      end
    end
  end
endmodule
